axis_dest_demux: RTL and testbench
==================================

Name: axis_dest_demux

Overview:
- Single-input, multi-output AXI-Stream router: the fan-out counterpart to the many-to-few arbitrating switch.
- Decodes the destination of each packet's head beat and steers the whole packet to one master port, locked until the last beat.
- Packets whose destination matches no port are dropped and counted.
- Sits between a producer (e.g. a command/queue dispatcher) and per-accelerator streams; each output has a 2-entry buffer for full throughput.

Parameters:
NMASTERS, 4, number of output ports (1..16)
DATA_WIDTH, 64, data beat width
DEST_WIDTH, 8, dest field width
ID_WIDTH, 1, id field width
HAS_LAST, 1, 1 = packets delimited by last; 0 = every beat is a 1-beat packet
DEST_BASE, 0, dest value of port 0
DEST_STRIDE, 1, dest increment between consecutive ports
DEST_RANGE, 0, port k matches [DEST_BASE+k*DEST_STRIDE, DEST_BASE+k*DEST_STRIDE+DEST_RANGE]; 0 = exact match

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  DATA_WIDTH  input data
s_dest  in  DEST_WIDTH  input dest (sampled on head beat)
s_id  in  ID_WIDTH  input id
s_last  in  1  end of packet (ignored if HAS_LAST=0)
m_valid  out  NMASTERS  per-port valid
m_ready  in  NMASTERS  per-port ready
m_data  out  NMASTERS*DATA_WIDTH  port k at [k*DATA_WIDTH +: DATA_WIDTH]
m_dest  out  NMASTERS*DEST_WIDTH  dest passed through unchanged on every beat
m_id  out  NMASTERS*ID_WIDTH  id passed through
m_last  out  NMASTERS  last passed through (1 on every beat if HAS_LAST=0)
drop_count  out  16  saturating count of dropped packets

Behaviour:
- Reset (aresetn=0, async): FSM=IDLE, all output buffers empty, m_valid=0, drop_count=0, s_ready=0 while in reset. Outputs m_data/m_dest/m_id/m_last are don't-care while m_valid=0.
- Decode (combinational, on s_dest): hit[k] per the DEST_RANGE rule. Overlapping ranges resolve to the lowest k. NMASTERS=1 means always port 0, no drop.
- FSM IDLE:
  - s_valid with a hit on port k: s_ready = buffer k not full.
  - On acceptance: sel<=k. Go to ROUTE unless (last||HAS_LAST=0), in which case stay IDLE.
  - s_valid with no hit: s_ready=1; beat discarded.
  - On that acceptance: drop_count++ (saturates at 0xFFFF). Go to DROP unless (last||HAS_LAST=0).
- FSM ROUTE:
  - s_ready = buffer[sel] not full; s_dest ignored (no re-decode mid-packet).
  - Accepted beat with last returns to IDLE.
- FSM DROP:
  - s_ready=1, beats discarded.
  - Accepted beat with last returns to IDLE.
- s_ready may depend combinationally on s_dest in IDLE only; it never depends on s_valid.
- Output buffer per port:
  - 2-entry FIFO, registered outputs.
  - A beat accepted at edge t is visible on m_valid[k] after edge t (1-cycle latency).
  - Simultaneous push and pop on the same cycle is allowed. A full buffer with a pop asserts s_ready the next cycle, not combinationally.
  - Sustains 1 beat/cycle per port when m_ready is held high.
- Ordering: beats within a port are delivered in input order. Packets are never interleaved on a port.
- Blocking: a stalled port k blocks the input only while the current/head packet targets k; no other port's m_valid is affected.
- AXIS rules: once m_valid[k]=1 it holds with stable payload until m_ready[k]=1.
- Reset mid-packet: the packet is truncated; buffered beats are discarded. The next accepted beat after reset is treated as a head beat and decoded.
- Widths: dest comparisons use DEST_WIDTH+5 bit unsigned arithmetic so base+k*stride+range does not wrap.

Test Plan:
- NMASTERS=4, exact match. 3-beat packet dest=2, all m_ready=1 -> m_valid[2] beats at cycles t+1..t+3, last on the 3rd beat; m_valid[0,1,3]=0 throughout.
- Head dest=1 then mid-packet beats carry dest=3 -> all beats exit port 1; dest field is passed through unchanged.
- m_ready[0]=0 with 4-beat packet to port 0 -> 2 beats buffered, then s_ready=0 until m_ready[0]=1; no beat lost or duplicated, order preserved.
- Back-to-back packets dest=0 then dest=3, m_ready[0]=0 -> second packet waits behind the first (s_ready=0); port 3 idle until the first packet is fully accepted.
- Packet dest=9 (no match), 5 beats -> s_ready=1 for all 5, no m_valid, drop_count 0->1. Drive 65536 dropped packets -> drop_count saturates at 0xFFFF.
- DEST_RANGE=3, DEST_STRIDE=4, dest=6 -> port 1. aresetn pulsed low mid-packet -> m_valid=0 and buffers empty immediately; next beat decoded as a head.

Source files
------------

// File: rtl/axis_dest_demux.sv
// Single-input AXI-Stream router: decodes the head beat's dest and steers the whole
// packet to one output port; unmatched packets are discarded and counted.
module axis_dest_demux #(
    parameter int NMASTERS    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 8,
    parameter int ID_WIDTH    = 1,
    parameter int HAS_LAST    = 1,
    parameter int DEST_BASE   = 0,
    parameter int DEST_STRIDE = 1,
    parameter int DEST_RANGE  = 0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic [DEST_WIDTH-1:0]          s_dest,
    input  logic [ID_WIDTH-1:0]            s_id,
    input  logic                           s_last,
    output logic [NMASTERS-1:0]            m_valid,
    input  logic [NMASTERS-1:0]            m_ready,
    output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
    output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
    output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
    output logic [NMASTERS-1:0]            m_last,
    output logic [15:0]                    drop_count
);

    localparam int SELW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CW   = DEST_WIDTH + 5;
    localparam int PW   = DATA_WIDTH + DEST_WIDTH + ID_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t            state_q;
    logic [SELW-1:0]   sel_q;
    logic [15:0]       drop_count_q;

    logic [CW-1:0]       dest_ext;
    logic [NMASTERS-1:0] hit;
    logic [NMASTERS-1:0] buf_full;
    logic [NMASTERS-1:0] push;
    logic                any_hit;
    logic [SELW-1:0]     hit_idx;
    logic                beat_last;
    logic                accept;
    logic                rdy;
    logic                route_now;
    logic [SELW-1:0]     route_idx;
    logic [PW-1:0]       s_payload;

    assign dest_ext  = CW'(s_dest);
    assign beat_last = (HAS_LAST != 0) ? s_last : 1'b1;
    assign s_payload = {s_data, s_dest, s_id, beat_last};
    assign accept    = s_valid && s_ready;

    // Widened bounds so base + k*stride + range never wraps inside DEST_WIDTH.
    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_dec
        localparam logic [CW-1:0] LO = CW'(DEST_BASE + gi * DEST_STRIDE);
        localparam logic [CW-1:0] HI = CW'(DEST_BASE + gi * DEST_STRIDE + DEST_RANGE);
        if (NMASTERS == 1) begin : g_one
            assign hit[gi] = 1'b1;
        end else if (LO == '0) begin : g_zero
            assign hit[gi] = (dest_ext <= HI);
        end else begin : g_win
            assign hit[gi] = (dest_ext >= LO) && (dest_ext <= HI);
        end
    end

    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int k = NMASTERS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any_hit = 1'b1;
                hit_idx = SELW'(k);
            end
        end
    end

    always_comb begin
        rdy = 1'b0;
        case (state_q)
            IDLE:    rdy = any_hit ? !buf_full[hit_idx] : 1'b1;
            ROUTE:   rdy = !buf_full[sel_q];
            DROP:    rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
        s_ready = aresetn && rdy;
    end

    assign route_now = ((state_q == IDLE) && any_hit) || (state_q == ROUTE);
    assign route_idx = (state_q == IDLE) ? hit_idx : sel_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            drop_count_q <= '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (any_hit) begin
                        sel_q   <= hit_idx;
                        state_q <= beat_last ? IDLE : ROUTE;
                    end else begin
                        if (drop_count_q != 16'hFFFF)
                            drop_count_q <= drop_count_q + 16'd1;
                        state_q <= beat_last ? IDLE : DROP;
                    end
                end
                ROUTE, DROP: begin
                    if (beat_last)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drop_count = drop_count_q;

    // Per-port 2-entry FIFO; slot0 is the registered output, slot1 the skid entry.
    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_port
        logic [1:0]    cnt_q;
        logic [1:0]    cnt_d;
        logic [PW-1:0] slot0_q;
        logic [PW-1:0] slot1_q;
        logic          pop;

        assign push[gi] = accept && route_now && (route_idx == SELW'(gi));
        assign pop      = (cnt_q != 2'd0) && m_ready[gi];

        always_comb begin
            cnt_d = cnt_q;
            case ({push[gi], pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)
                cnt_q <= 2'd0;
            else
                cnt_q <= cnt_d;
        end

        always_ff @(posedge aclk) begin
            if ((cnt_q == 2'd2) && pop)
                slot0_q <= slot1_q;
            else if (push[gi] && ((cnt_q == 2'd0) || pop))
                slot0_q <= s_payload;
            if (push[gi] && (cnt_q == 2'd1) && !pop)
                slot1_q <= s_payload;
        end

        assign buf_full[gi] = (cnt_q == 2'd2);
        assign m_valid[gi]  = (cnt_q != 2'd0);
        assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot0_q[PW-1 -: DATA_WIDTH];
        assign m_dest[gi*DEST_WIDTH +: DEST_WIDTH] = slot0_q[ID_WIDTH+1 +: DEST_WIDTH];
        assign m_id[gi*ID_WIDTH +: ID_WIDTH]       = slot0_q[1 +: ID_WIDTH];
        assign m_last[gi]                          = slot0_q[0];
    end

endmodule

// File: tb/tb_axis_dest_demux.sv
// Directed bench for axis_dest_demux: per-port scoreboard queues filled at input
// acceptance and drained by a negedge monitor, plus directed cycle-level checks.
module tb_axis_dest_demux;

    localparam int NM = 4;
    localparam int DW = 64;
    localparam int TW = 8;
    localparam int PW = DW + TW + 2;

    logic           aclk;
    logic           aresetn;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic [TW-1:0]  s_dest;
    logic [0:0]     s_id;
    logic           s_last;
    logic [NM-1:0]  m_valid;
    logic [NM-1:0]  m_ready;
    logic [NM*DW-1:0] m_data;
    logic [NM*TW-1:0] m_dest;
    logic [NM-1:0]  m_id;
    logic [NM-1:0]  m_last;
    logic [15:0]    drop_count;

    logic           r_s_valid;
    logic           r_s_ready;
    logic [7:0]     r_s_data;
    logic [7:0]     r_s_dest;
    logic [0:0]     r_s_id;
    logic           r_s_last;
    logic [3:0]     r_m_valid;
    logic [3:0]     r_m_ready;
    logic [31:0]    r_m_data;
    logic [31:0]    r_m_dest;
    logic [3:0]     r_m_id;
    logic [3:0]     r_m_last;
    logic [15:0]    r_drop_count;

    int vectors = 0;
    int miscompares = 0;
    int last_wait = 0;

    logic [PW-1:0] exp_q [NM][$];
    logic [NM-1:0] stall_prev = '0;
    logic [PW-1:0] pay_prev [NM];

    axis_dest_demux u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest),
        .s_id(s_id), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest),
        .m_id(m_id), .m_last(m_last), .drop_count(drop_count)
    );

    axis_dest_demux #(
        .NMASTERS(4), .DATA_WIDTH(8), .DEST_WIDTH(8), .ID_WIDTH(1), .HAS_LAST(1),
        .DEST_BASE(0), .DEST_STRIDE(4), .DEST_RANGE(3)
    ) u_rng (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data), .s_dest(r_s_dest),
        .s_id(r_s_id), .s_last(r_s_last),
        .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data), .m_dest(r_m_dest),
        .m_id(r_m_id), .m_last(r_m_last), .drop_count(r_drop_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] port_payload(input int k);
        return {m_data[k*DW +: DW], m_dest[k*TW +: TW], m_id[k], m_last[k]};
    endfunction

    // Output monitor: every delivered beat must match the head of its port queue.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = '0;
        end else begin
            for (int k = 0; k < NM; k++) begin
                if (stall_prev[k]) begin
                    chk($sformatf("hold_valid_p%0d", k), 128'(m_valid[k]), 128'(1'b1));
                    chk($sformatf("hold_payload_p%0d", k), 128'(port_payload(k)), 128'(pay_prev[k]));
                end
                if (m_valid[k]) begin
                    chk($sformatf("spurious_p%0d", k), 128'(m_valid[k]),
                        128'(exp_q[k].size() != 0));
                    if (m_ready[k] && exp_q[k].size() != 0)
                        chk($sformatf("beat_p%0d", k), 128'(port_payload(k)),
                            128'(exp_q[k].pop_front()));
                end
                stall_prev[k] = m_valid[k] && !m_ready[k];
                pay_prev[k]   = port_payload(k);
            end
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic [TW-1:0] dst,
                         input logic idv, input logic lst);
        s_valid = 1'b1;
        s_data  = d;
        s_dest  = dst;
        s_id    = idv;
        s_last  = lst;
    endtask

    task automatic wait_accept(input int port);
        int n;
        n = 0;
        @(negedge aclk);
        while (!s_ready && n < 40) begin
            n++;
            @(negedge aclk);
        end
        last_wait = n;
        chk("accept_timeout", 128'(s_ready), 128'(1'b1));
        if (s_ready && port >= 0)
            exp_q[port].push_back({s_data, s_dest, s_id, s_last});
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input int port, input logic [TW-1:0] dh, input logic [TW-1:0] dm,
                            input int nb, input logic idv, input logic [DW-1:0] base);
        for (int i = 0; i < nb; i++) begin
            drive(base + DW'(i), (i == 0) ? dh : dm, idv, (i == nb - 1));
            wait_accept(port);
            chk("full_rate", 128'(last_wait), 128'(0));
        end
    endtask

    task automatic drain();
        repeat (5) @(posedge aclk);
        #1;
        chk("drain_empty", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()
            + exp_q[3].size()), 128'(0));
    endtask

    initial begin
        logic [7:0] rng_dest [5];
        logic [3:0] rng_exp  [5];
        rng_dest = '{8'd6, 8'd3, 8'd16, 8'd12, 8'd15};
        rng_exp  = '{4'b0010, 4'b0001, 4'b0000, 4'b1000, 4'b1000};

        aresetn = 1'b0;
        m_ready = 4'hF;
        drive(64'h0, 8'd0, 1'b0, 1'b1);
        r_s_valid = 1'b0; r_s_data = '0; r_s_dest = '0; r_s_id = '0; r_s_last = 1'b1;
        r_m_ready = 4'hF;

        // Reset state.
        @(negedge aclk);
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_drop_count", 128'(drop_count), 128'(0));
        @(posedge aclk); #1;
        aresetn = 1'b1;
        s_valid = 1'b0;

        // Range decode: port k covers [4k, 4k+3].
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            r_s_valid = 1'b1;
            r_s_dest  = rng_dest[i];
            r_s_data  = 8'hA0 + 8'(i);
            @(negedge aclk);
            chk("rng_ready", 128'(r_s_ready), 128'(1));
            @(posedge aclk); #1;
            r_s_valid = 1'b0;
            chk($sformatf("rng_port_dest%0d", rng_dest[i]), 128'(r_m_valid), 128'(rng_exp[i]));
        end
        chk("rng_drop_count", 128'(r_drop_count), 128'(1));

        // 3-beat packet to port 2 at full rate, 1-cycle latency.
        @(posedge aclk); #1;
        for (int i = 0; i < 3; i++) begin
            drive(64'h2000 + 64'(i), 8'd2, 1'b0, (i == 2));
            wait_accept(2);
            chk("t1_wait", 128'(last_wait), 128'(0));
            chk("t1_m_valid", 128'(m_valid), 128'(4'b0100));
        end
        chk("t1_last", 128'(m_last[2]), 128'(1));
        @(posedge aclk); #1;
        chk("t1_idle", 128'(m_valid), 128'(0));
        drain();

        // Head dest=1, later beats carry dest=3: stays on port 1.
        send_pkt(1, 8'd1, 8'd3, 4, 1'b1, 64'h1100);
        drain();

        // Port 0 stalled: two beats buffered, then backpressure.
        m_ready = 4'b1110;
        drive(64'h0A0, 8'd0, 1'b0, 1'b0); wait_accept(0);
        drive(64'h0A1, 8'd0, 1'b0, 1'b0); wait_accept(0);
        drive(64'h0A2, 8'd0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge aclk);
            chk("stall_s_ready", 128'(s_ready), 128'(0));
            chk("stall_m_valid0", 128'(m_valid[0]), 128'(1));
        end
        @(posedge aclk); #1;
        m_ready = 4'hF;
        wait_accept(0);
        drive(64'h0A3, 8'd0, 1'b0, 1'b1); wait_accept(0);
        drain();

        // Packet to port 3 waits behind a stalled packet to port 0.
        m_ready = 4'b1110;
        drive(64'h0B0, 8'd0, 1'b0, 1'b0); wait_accept(0);
        drive(64'h0B1, 8'd0, 1'b0, 1'b0); wait_accept(0);
        drive(64'h0B2, 8'd0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge aclk);
            chk("hol_s_ready", 128'(s_ready), 128'(0));
            chk("hol_port3_idle", 128'(m_valid[3]), 128'(0));
        end
        @(posedge aclk); #1;
        m_ready = 4'hF;
        wait_accept(0);
        send_pkt(3, 8'd3, 8'd3, 2, 1'b1, 64'h3300);
        drain();

        // Unmatched dest: 5 beats discarded, one drop counted.
        send_pkt(-1, 8'd9, 8'd9, 5, 1'b0, 64'h9900);
        @(negedge aclk);
        chk("drop_count_1", 128'(drop_count), 128'(1));

        // Saturation of the drop counter.
        @(posedge aclk); #1;
        drive(64'h0, 8'd9, 1'b0, 1'b1);
        repeat (65533) @(posedge aclk);
        #1;
        chk("drop_count_fffe", 128'(drop_count), 128'(16'hFFFE));
        @(posedge aclk); #1;
        chk("drop_count_ffff", 128'(drop_count), 128'(16'hFFFF));
        repeat (2) @(posedge aclk);
        #1;
        chk("drop_count_sat", 128'(drop_count), 128'(16'hFFFF));
        s_valid = 1'b0;
        drain();

        // Reset mid-packet with port 1 holding buffered beats.
        m_ready = 4'b1101;
        drive(64'h1D0, 8'd1, 1'b0, 1'b0); wait_accept(1);
        drive(64'h1D1, 8'd1, 1'b0, 1'b0); wait_accept(1);
        aresetn = 1'b0;
        for (int k = 0; k < NM; k++) exp_q[k].delete();
        #1;
        chk("mid_rst_m_valid", 128'(m_valid), 128'(0));
        chk("mid_rst_s_ready", 128'(s_ready), 128'(0));
        chk("mid_rst_drop_count", 128'(drop_count), 128'(0));
        @(posedge aclk); #1;
        aresetn = 1'b1;
        m_ready = 4'hF;
        drive(64'h2E0, 8'd2, 1'b0, 1'b1);
        wait_accept(2);
        chk("post_rst_head", 128'(m_valid), 128'(4'b0100));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
